// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding, edit-field codes and wrap helper for the clock setting controller.
// The alarm states are present only when CLOCK_SET_CTRL_ALARM_EN is defined.
package clock_ctrl_pkg;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   typedef enum logic [1:0] {
      EF_NONE  = 2'd0,
      EF_HOUR  = 2'd1,
      EF_MIN   = 2'd2,
      EF_ALARM = 2'd3
   } edit_field_e;

`ifdef CLOCK_SET_CTRL_ALARM_EN
   typedef enum logic [2:0] {
      RUN         = 3'd0,
      SET_HOUR    = 3'd1,
      SET_MIN     = 3'd2,
      COMMIT      = 3'd3,
      SET_AL_HOUR = 3'd4,
      SET_AL_MIN  = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HOUR = 3'd1,
      SET_MIN  = 3'd2,
      COMMIT   = 3'd3
   } state_e;
`endif

   // Increment with wrap to zero once the field maximum is reached.
   function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_value);
      return (value == max_value) ? 6'd0 : value + 6'd1;
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// Rising-edge detector for a synchronous button, with an optional held-button
// auto-repeat that fires once per cycle after REPEAT_TICKS consecutive held cycles.
module btn_pulse #(
   parameter bit REPEAT_EN    = 1'b0,
   parameter int REPEAT_TICKS = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse,
   output logic rpt
);

   logic btn_prev;

   // NOTE: the previous sample resets high so a button held through reset release is not a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev <= 1'b1;
      end else begin
         btn_prev <= btn;
      end
   end

   assign pulse = btn & ~btn_prev;

   generate
      if (REPEAT_EN) begin : g_repeat
         localparam int CW = $clog2(REPEAT_TICKS + 1);
         localparam logic [CW-1:0] CNT_SAT = CW'(REPEAT_TICKS);

         logic [CW-1:0] held_cnt;

         // Counts earlier held cycles, so repeat begins on the cycle after REPEAT_TICKS held cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               held_cnt <= '0;
            end else if (!btn) begin
               held_cnt <= '0;
            end else if (held_cnt != CNT_SAT) begin
               held_cnt <= held_cnt + CW'(1);
            end
         end

         assign rpt = btn && (held_cnt == CNT_SAT);
      end else begin : g_no_repeat
         assign rpt = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: captures the live time, edits hour then minute, and
// issues a one-cycle load strobe. CLOCK_SET_CTRL_ALARM_EN adds alarm editing and alarm_ring.
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int HOURS_MAX    = 23,
   parameter int REPEAT_TICKS = 3
) (
   input  logic       Clk_1sec,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] cur_seconds,
   input  logic [5:0] cur_minutes,
   input  logic [4:0] cur_hours,
   output logic       load_en,
   output logic [5:0] load_seconds,
   output logic [5:0] load_minutes,
   output logic [4:0] load_hours,
   output logic [1:0] edit_field
`ifdef CLOCK_SET_CTRL_ALARM_EN
   ,
   output logic       alarm_ring
`endif
);

   localparam logic [5:0] H_MAX = 6'(HOURS_MAX);
   localparam logic [5:0] M_MAX = 6'(MIN_MAX);

   state_e     state, state_next;
   logic [4:0] edit_h, edit_h_next;
   logic [5:0] edit_m, edit_m_next;
   logic       mode_pulse, inc_pulse, inc_rpt, inc_evt;
   logic       unused_mode_rpt;

`ifdef CLOCK_SET_CTRL_ALARM_EN
   logic [4:0] al_h, al_h_next;
   logic [5:0] al_m, al_m_next;
`endif

   btn_pulse #(.REPEAT_EN(1'b0), .REPEAT_TICKS(REPEAT_TICKS)) u_mode_btn (
      .clk   (Clk_1sec),
      .rst_n (reset_n),
      .btn   (btn_mode),
      .pulse (mode_pulse),
      .rpt   (unused_mode_rpt)
   );

   btn_pulse #(.REPEAT_EN(1'b1), .REPEAT_TICKS(REPEAT_TICKS)) u_inc_btn (
      .clk   (Clk_1sec),
      .rst_n (reset_n),
      .btn   (btn_inc),
      .pulse (inc_pulse),
      .rpt   (inc_rpt)
   );

   assign inc_evt = inc_pulse | inc_rpt;

   // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_next  = state;
      edit_h_next = edit_h;
      edit_m_next = edit_m;
`ifdef CLOCK_SET_CTRL_ALARM_EN
      al_h_next   = al_h;
      al_m_next   = al_m;
`endif
      case (state)
         RUN: begin
            if (mode_pulse) begin
               state_next  = SET_HOUR;
               edit_h_next = ({1'b0, cur_hours} > H_MAX) ? 5'd0 : cur_hours;
               edit_m_next = (cur_minutes > M_MAX) ? 6'd0 : cur_minutes;
            end
         end
         // Mode has priority over an increment arriving in the same cycle.
         SET_HOUR: begin
            if (mode_pulse) begin
               state_next = SET_MIN;
            end else if (inc_evt) begin
               edit_h_next = 5'(wrap_inc({1'b0, edit_h}, H_MAX));
            end
         end
         SET_MIN: begin
            if (mode_pulse) begin
`ifdef CLOCK_SET_CTRL_ALARM_EN
               state_next = SET_AL_HOUR;
`else
               state_next = COMMIT;
`endif
            end else if (inc_evt) begin
               edit_m_next = wrap_inc(edit_m, M_MAX);
            end
         end
`ifdef CLOCK_SET_CTRL_ALARM_EN
         SET_AL_HOUR: begin
            if (mode_pulse) begin
               state_next = SET_AL_MIN;
            end else if (inc_evt) begin
               al_h_next = 5'(wrap_inc({1'b0, al_h}, H_MAX));
            end
         end
         SET_AL_MIN: begin
            if (mode_pulse) begin
               state_next = COMMIT;
            end else if (inc_evt) begin
               al_m_next = wrap_inc(al_m, M_MAX);
            end
         end
`endif
         COMMIT:  state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      edit_field = EF_NONE;
      case (state)
         SET_HOUR:    edit_field = EF_HOUR;
         SET_MIN:     edit_field = EF_MIN;
`ifdef CLOCK_SET_CTRL_ALARM_EN
         SET_AL_HOUR: edit_field = EF_ALARM;
         SET_AL_MIN:  edit_field = EF_ALARM;
`endif
         default:     edit_field = EF_NONE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk_1sec or negedge reset_n) begin
      if (!reset_n) begin
         state        <= RUN;
         edit_h       <= '0;
         edit_m       <= '0;
         load_en      <= 1'b0;
         load_hours   <= '0;
         load_minutes <= '0;
      end else begin
         state   <= state_next;
         edit_h  <= edit_h_next;
         edit_m  <= edit_m_next;
         // Load outputs are registered on entry so they are valid throughout COMMIT.
         load_en <= (state_next == COMMIT);
         if (state_next == COMMIT) begin
            load_hours   <= edit_h;
            load_minutes <= edit_m;
         end
      end
   end

   // Seconds always restart from zero on a load.
   assign load_seconds = 6'd0;

`ifdef CLOCK_SET_CTRL_ALARM_EN
   always_ff @(posedge Clk_1sec or negedge reset_n) begin
      if (!reset_n) begin
         al_h       <= '0;
         al_m       <= '0;
         alarm_ring <= 1'b0;
      end else begin
         al_h <= al_h_next;
         al_m <= al_m_next;
         // Any button press or the minute moving on silences the alarm.
         if (mode_pulse || inc_pulse || (cur_minutes != al_m)) begin
            alarm_ring <= 1'b0;
         end else if ((state == RUN) && (cur_seconds == 6'd0) && (cur_hours == al_h)) begin
            alarm_ring <= 1'b1;
         end
      end
   end
`else
   logic unused_cur_seconds;
   assign unused_cur_seconds = ^cur_seconds;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected loads are queued as edits are
// issued and a monitor compares them whenever load_en is presented.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] cur_seconds = 6'd15;
   logic [5:0] cur_minutes = 6'd0;
   logic [4:0] cur_hours = 5'd0;
   logic       load_en;
   logic [5:0] load_seconds, load_minutes;
   logic [4:0] load_hours;
   logic [1:0] edit_field;
`ifdef CLOCK_SET_CTRL_ALARM_EN
   logic       alarm_ring;
`endif

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } load_t;

   load_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   logic  load_en_d = 1'b0;

   clock_set_ctrl #(.HOURS_MAX(23), .REPEAT_TICKS(3)) dut (
      .Clk_1sec     (clk),
      .reset_n      (rst_n),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .cur_seconds  (cur_seconds),
      .cur_minutes  (cur_minutes),
      .cur_hours    (cur_hours),
      .load_en      (load_en),
      .load_seconds (load_seconds),
      .load_minutes (load_minutes),
      .load_hours   (load_hours),
      .edit_field   (edit_field)
`ifdef CLOCK_SET_CTRL_ALARM_EN
      ,
      .alarm_ring   (alarm_ring)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every load strobe must be one cycle wide and match the oldest queued edit.
   always @(negedge clk) begin
      load_t e;
      if (load_en === 1'b1) begin
         check("load_width", load_en_d, 0);
         check("load_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("load_hours", load_hours, e.h);
            check("load_minutes", load_minutes, e.m);
            check("load_seconds", load_seconds, e.s);
         end
      end
      load_en_d = load_en;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      tick();
      btn_mode = 1'b0;
      tick();
   endtask

   task automatic press_inc(input int n = 1);
      repeat (n) begin
         btn_inc = 1'b1;
         tick();
         btn_inc = 1'b0;
         tick();
      end
   endtask

   task automatic hold_inc(input int n);
      btn_inc = 1'b1;
      tick(n);
      btn_inc = 1'b0;
      tick();
   endtask

   task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      cur_hours   = h;
      cur_minutes = m;
      cur_seconds = s;
   endtask

   task automatic expect_load(input logic [4:0] h, input logic [5:0] m);
      load_t e;
      e.h = h;
      e.m = m;
      e.s = 6'd0;
      exp_q.push_back(e);
   endtask

   // Leaves SET_MIN (stepping through the alarm fields untouched when present) and commits.
   task automatic commit_edit(input logic [4:0] h, input logic [5:0] m);
`ifdef CLOCK_SET_CTRL_ALARM_EN
      press_mode();
      press_mode();
`endif
      expect_load(h, m);
      press_mode();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      // Reset with btn_mode held: no edit may start on release.
      btn_mode = 1'b1;
      rst_n    = 1'b0;
      tick(2);
      check("rst_load_en", load_en, 0);
      check("rst_load_hours", load_hours, 0);
      check("rst_load_minutes", load_minutes, 0);
      check("rst_edit_field", edit_field, 0);
      rst_n = 1'b1;
      tick(4);
      check("held_mode_no_edit", edit_field, 0);
      btn_mode = 1'b0;
      tick(2);
      check("held_mode_released", edit_field, 0);

      // Increment in RUN is ignored, then 10:20 -> 13:21:00.
      set_time(5'd10, 6'd20, 6'd15);
      hold_inc(5);
      check("run_inc_ignored", edit_field, 0);
      press_mode();
      check("ef_hour", edit_field, 1);
      press_inc(3);
      press_mode();
      check("ef_min", edit_field, 2);
      press_inc(1);
      commit_edit(5'd13, 6'd21);
      check("ef_after_commit", edit_field, 0);

      // Wrap at both maxima: 23:59 -> 00:00:00.
      set_time(5'd23, 6'd59, 6'd15);
      press_mode();
      press_inc(1);
      press_mode();
      press_inc(1);
      commit_edit(5'd0, 6'd0);

      // Out-of-range live time is clamped to zero before editing.
      set_time(5'd30, 6'd63, 6'd15);
      press_mode();
      press_inc(1);
      press_mode();
      press_inc(2);
      commit_edit(5'd1, 6'd2);

      // Mode+inc together in SET_HOUR, then a 6-cycle hold from 5 minutes.
      set_time(5'd0, 6'd5, 6'd15);
      press_mode();
      check("ef_hour_2", edit_field, 1);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      tick();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      tick();
      check("mode_wins_ef", edit_field, 2);
      hold_inc(6);
      commit_edit(5'd0, 6'd9);

      // Reset mid-edit abandons the edit without a load strobe.
      set_time(5'd4, 6'd4, 6'd15);
      press_mode();
      press_mode();
      check("ef_min_before_rst", edit_field, 2);
      rst_n = 1'b0;
      tick();
      check("ef_in_rst", edit_field, 0);
      rst_n = 1'b1;
      tick(5);
      check("ef_after_rst", edit_field, 0);

`ifdef CLOCK_SET_CTRL_ALARM_EN
      // Alarm set to 07:30 (30 minutes via a 32-cycle hold), then rung and cleared.
      set_time(5'd5, 6'd0, 6'd15);
      press_mode();
      press_mode();
      press_mode();
      check("ef_al_hour", edit_field, 3);
      press_inc(7);
      press_mode();
      check("ef_al_min", edit_field, 3);
      hold_inc(32);
      expect_load(5'd5, 6'd0);
      press_mode();
      tick();
      check("ring_idle", alarm_ring, 0);
      set_time(5'd7, 6'd30, 6'd0);
      tick(2);
      check("ring_set", alarm_ring, 1);
      btn_inc = 1'b1;
      tick();
      check("ring_cleared", alarm_ring, 0);
      btn_inc     = 1'b0;
      cur_seconds = 6'd15;
      tick(2);
      check("ring_stays_clear", alarm_ring, 0);
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      check("pending_loads", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter HOURS_MAX, default 23, the largest hour value before wrap to 0.
REQ-002 SHALL have parameter REPEAT_TICKS, default 3, the number of consecutive held cycles of btn_inc before auto-repeat starts.
REQ-003 SHALL have port Clk_1sec, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports btn_mode and btn_inc, inputs, 1 bit each, already synchronous to Clk_1sec.
REQ-006 SHALL have ports cur_seconds, cur_minutes and cur_hours, inputs of 6, 6 and 5 bits: the live time from the Digital_Clock counter.
REQ-007 SHALL have port load_en, output, 1 bit: a one-cycle load strobe to the clock counter.
REQ-008 SHALL have ports load_seconds, load_minutes and load_hours, outputs of 6, 6 and 5 bits: the registered load values.
REQ-009 SHALL have port edit_field, output, 2 bits: 0 = none, 1 = hour, 2 = minute, 3 = alarm field.

Function
REQ-010 SHALL form mode_pulse and inc_pulse as rising edges: the input is high now and its registered previous sample is low.
REQ-011 SHALL implement a Moore FSM with states RUN, SET_HOUR, SET_MIN and COMMIT.
REQ-012 In RUN, on mode_pulse, SHALL capture cur_hours into edit_h and cur_minutes into edit_m, then go to SET_HOUR.
  - A captured value above its maximum (HOURS_MAX for hours, 59 for minutes) SHALL be clamped to 0.
REQ-013 In SET_HOUR, each increment event SHALL change edit_h to (edit_h == HOURS_MAX) ? 0 : edit_h + 1; mode_pulse SHALL go to SET_MIN.
REQ-014 In SET_MIN, each increment event SHALL apply the same rule to edit_m with a maximum of 59; mode_pulse SHALL go to COMMIT.
REQ-015 An increment event SHALL be either of:
  - inc_pulse;
  - btn_inc held high for at least REPEAT_TICKS consecutive cycles, which gives one event per cycle from then on.
REQ-016 The held-cycle counter SHALL saturate at REPEAT_TICKS and SHALL clear in the cycle btn_inc is low.
REQ-017 If mode_pulse and an increment event occur in the same cycle in a SET state, mode SHALL win and no increment SHALL occur.
REQ-018 COMMIT SHALL last exactly one cycle and SHALL then go unconditionally to RUN.
REQ-019 During COMMIT, load_en SHALL be 1, with load_hours = edit_h, load_minutes = edit_m and load_seconds = 0; load_en SHALL be 0 in every other state.
REQ-020 load_en SHALL rise in the cycle after the mode_pulse that left SET_MIN: a latency of 1 cycle.
REQ-021 In RUN, btn_inc SHALL have no effect.
REQ-022 edit_field SHALL be a direct decode of the state; it SHALL be 0 in RUN and COMMIT.

Reset
REQ-023 While reset_n is low, state SHALL be RUN and the following SHALL all be 0:
  - load_en, load_seconds, load_minutes, load_hours, edit_h, edit_m, the held-cycle counter.
REQ-024 The previous-sample button registers SHALL reset to 1, so a button held through reset release produces no pulse.
REQ-025 Reset asserted mid-edit SHALL abandon the edit with no load_en strobe.

Configuration
REQ-026 Macro CLOCK_SET_CTRL_ALARM_EN SHALL, when defined, add the states SET_AL_HOUR and SET_AL_MIN.
  - From SET_MIN, mode_pulse SHALL go to SET_AL_HOUR, then SET_AL_MIN, then COMMIT.
  - These states edit the registers al_h and al_m (reset value 0) using the REQ-013/014 rules; edit_field SHALL be 3 in both.
REQ-027 With the macro defined, the block SHALL add output alarm_ring, 1 bit, registered, reset 0.
  - It SHALL set when state is RUN, cur_seconds == 0, cur_hours == al_h and cur_minutes == al_m.
  - It SHALL clear on mode_pulse or inc_pulse, or when cur_minutes != al_m.
REQ-028 Without the macro, no alarm states, registers or port SHALL exist, and SET_MIN mode_pulse SHALL go to COMMIT.

Structure
REQ-029 Package clock_ctrl_pkg SHALL hold:
  - the state enum;
  - SEC_MAX = 59 and MIN_MAX = 59;
  - the edit_field encodings.
REQ-030 Sub-module btn_pulse SHALL perform edge detection and the optional held-repeat counter; it SHALL be instantiated once per button, with repeat disabled for btn_mode.

Verification
REQ-031 Reset with btn_mode held high, then release -> no state change; state stays RUN.
REQ-032 Time 10:20, mode, inc x3, mode, inc x1, mode -> one-cycle load_en with 13:21:00, then RUN.
REQ-033 In SET_HOUR with edit_h = 23, inc -> edit_h = 0; in SET_MIN with edit_m = 59, inc -> edit_m = 0.
REQ-034 btn_inc held 6 cycles in SET_MIN from edit_m = 5 -> edit_m = 9 (1 edge event plus 3 repeat events); mode and inc in the same cycle -> no increment.
REQ-035 reset_n pulsed low while in SET_MIN -> RUN with load_en never asserted.
REQ-036 With CLOCK_SET_CTRL_ALARM_EN: set the alarm to 07:30, drive the time to 07:30:00 -> alarm_ring = 1; an inc_pulse clears it.
